// File: rtl/mat_mult_matrix_test_pkg.sv
// Shared sizing and indexing helpers for the
// matrix-multiply exerciser.
package mat_mult_matrix_test_pkg;

  localparam int DEF_DATA_WIDTH = 3;
  localparam int DEF_N_COLUMNS  = 3;
  localparam int DEF_M_ROWS     = 3;

  // Accumulator width: one full product plus
  // enough headroom for n_columns of them.
  function automatic int ew(
    input int data_width,
    input int n_columns
  );
    return 2 * data_width + $clog2(n_columns);
  endfunction

  // Circulant index used to build A and B.
  function automatic int circ(
    input int i,
    input int j,
    input int n
  );
    return (i + j) % n;
  endfunction

endpackage

// File: rtl/mat_mult_matrix_test_matrix_dot_row.sv
// Combinational dot product of two packed
// unsigned vectors of n_columns elements.
module matrix_dot_row
  import mat_mult_matrix_test_pkg::*;
#(
  parameter int data_width = DEF_DATA_WIDTH,
  parameter int n_columns  = DEF_N_COLUMNS,
  parameter int ew_width   = ew(data_width, n_columns)
) (
  input  logic [n_columns*data_width-1:0] a_vec,
  input  logic [n_columns*data_width-1:0] b_vec,
  output logic [ew_width-1:0]             dot
);

  localparam int PW = 2 * data_width;

  logic [PW-1:0]       a_el;
  logic [PW-1:0]       b_el;
  logic [PW-1:0]       prod;
  logic [ew_width-1:0] acc;

  // Sum of element products; width never overflows.
  always_comb begin
    a_el = '0;
    b_el = '0;
    prod = '0;
    acc  = '0;
    for (int k = 0; k < n_columns; k++) begin
      a_el = {{data_width{1'b0}},
              a_vec[k*data_width +: data_width]};
      b_el = {{data_width{1'b0}},
              b_vec[k*data_width +: data_width]};
      prod = a_el * b_el;
      acc  = acc + ew_width'(prod);
    end
    dot = acc;
  end

endmodule

// File: rtl/mat_mult_matrix_test.sv
// Free-running counter feeding a circulant
// matrix product, registered every clock.
module mat_mult_matrix_test
  import mat_mult_matrix_test_pkg::*;
#(
  parameter int data_width = DEF_DATA_WIDTH,
  parameter int n_columns  = DEF_N_COLUMNS,
  parameter int m_rows     = DEF_M_ROWS,
  localparam int EW = ew(data_width, n_columns),
  localparam int CW = n_columns * data_width,
  localparam int OW = EW * m_rows * n_columns
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic [OW-1:0] outp,
  output logic [CW-1:0] outp_inps
);

  logic [CW-1:0] cnt;
  logic [OW-1:0] c_flat;

  for (genvar gi = 0; gi < m_rows; gi++) begin : g_row
    for (genvar gj = 0; gj < n_columns; gj++) begin : g_col
      logic [CW-1:0] a_row;
      logic [CW-1:0] b_col;

      for (genvar gk = 0; gk < n_columns; gk++) begin : g_k
        assign a_row[gk*data_width +: data_width] =
          cnt[circ(gi, gk, n_columns)*data_width
              +: data_width];
        assign b_col[gk*data_width +: data_width] =
          cnt[circ(gk, gj, n_columns)*data_width
              +: data_width];
      end

      matrix_dot_row #(
        .data_width (data_width),
        .n_columns  (n_columns),
        .ew_width   (EW)
      ) u_dot (
        .a_vec (a_row),
        .b_vec (b_col),
        .dot   (c_flat[(gi*n_columns+gj)*EW +: EW])
      );
    end
  end

  // Advance the counter and capture C with the
  // count it was computed from.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      outp      <= '0;
      outp_inps <= '0;
    end else begin
      cnt       <= cnt + CW'(1);
      outp      <= c_flat;
      outp_inps <= cnt;
    end
  end

endmodule

// File: tb/tb_mat_mult_matrix_test.sv
// Scoreboard bench for the matrix-multiply
// exerciser at default parameters.
module tb_mat_mult_matrix_test;

  localparam int DW = 3;
  localparam int NC = 3;
  localparam int MR = 3;
  localparam int EW = 8;
  localparam int OW = EW * MR * NC;
  localparam int CW = NC * DW;

  typedef struct packed {
    logic [CW-1:0] inps;
    logic [OW-1:0] c;
  } exp_t;

  logic          tb_clk;
  logic          rst_n;
  logic [OW-1:0] outp;
  logic [CW-1:0] outp_inps;

  int   checks;
  int   failures;
  int   model_cnt;
  exp_t sb[$];

  mat_mult_matrix_test #(
    .data_width (DW),
    .n_columns  (NC),
    .m_rows     (MR)
  ) dut (
    .clk       (tb_clk),
    .rst_n     (rst_n),
    .outp      (outp),
    .outp_inps (outp_inps)
  );

  initial tb_clk = 1'b0;
  always #5 tb_clk = ~tb_clk;

  function automatic logic [OW-1:0] ref_c(
    input int c
  );
    int v[NC];
    int s;
    logic [OW-1:0] r;
    r = '0;
    for (int k = 0; k < NC; k++)
      v[k] = (c >> (k * DW)) & ((1 << DW) - 1);
    for (int i = 0; i < MR; i++)
      for (int j = 0; j < NC; j++) begin
        s = 0;
        for (int k = 0; k < NC; k++)
          s += v[(i + k) % NC] * v[(k + j) % NC];
        r[(i*NC+j)*EW +: EW] = s[EW-1:0];
      end
    return r;
  endfunction

  task automatic chk(
    input string         tag,
    input logic [OW-1:0] obs,
    input logic [OW-1:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  // One clock: predict, clock, then compare.
  task automatic step();
    exp_t e;
    e.inps = model_cnt[CW-1:0];
    e.c    = ref_c(model_cnt);
    sb.push_back(e);
    model_cnt = (model_cnt + 1) % (1 << CW);
    @(posedge tb_clk);
    #1;
    e = sb.pop_front();
    chk("sb_inps", OW'(outp_inps), OW'(e.inps));
    chk("sb_outp", outp, e.c);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    model_cnt = 0;
    rst_n     = 1'b0;
    repeat (2) @(posedge tb_clk);
    #1;
    chk("rst_outp", outp, '0);
    chk("rst_inps", OW'(outp_inps), '0);
    @(negedge tb_clk);
    rst_n = 1'b1;

    step();
    chk("first_outp", outp, '0);
    step();
    chk("ident", outp,
        72'h010000000100000001);
    step();
    chk("scale", outp,
        72'h040000000400000004);
    repeat (7) step();
    chk("mixed_inps", OW'(outp_inps), OW'(9));
    chk("mixed", outp,
        72'h020101010201010102);
    repeat (28) step();
    chk("pre_rst_inps", OW'(outp_inps), OW'(37));

    #3;
    rst_n = 1'b0;
    #1;
    chk("async_outp", outp, '0);
    chk("async_inps", OW'(outp_inps), '0);
    @(posedge tb_clk);
    #1;
    chk("held_outp", outp, '0);
    @(negedge tb_clk);
    rst_n = 1'b1;
    sb.delete();
    model_cnt = 0;

    step();
    chk("restart0", OW'(outp_inps), OW'(0));
    step();
    chk("restart1", OW'(outp_inps), OW'(1));
    step();
    chk("restart2", OW'(outp_inps), OW'(2));
    repeat (509) step();
    chk("max_inps", OW'(outp_inps), OW'(511));
    chk("max", outp,
        72'h939393939393939393);
    step();
    chk("wrap_inps", OW'(outp_inps), OW'(0));
    chk("wrap_outp", outp, '0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/mat_mult_matrix_test.md
# mat_mult_matrix_test

Self-contained matrix-multiply exerciser. An internal free-running counter generates a packed input vector. The vector is expanded into two circulant matrices, and their product is registered out every clock. It sits at the top of the matrix-multiply test harness as both stimulus source and datapath under observation. It has no external data inputs.

## Interface
- `data_width`, default 3: bit width of each input element.
- `n_columns`, default 3: elements per input vector; inner dimension; columns of A, B and C.
- `m_rows`, default 3: rows of A and C.
- One clock; reset is asynchronous and active-low.
- `clk`  in  1: rising-edge clock.
- `rst_n`  in  1: asynchronous active-low reset.
- `outp`  out  EW*m_rows*n_columns, where EW = 2*data_width + clog2(n_columns); EW = 8 and width = 72 at defaults: packed result matrix C.
- `outp_inps`  out  n_columns*data_width: counter value from which the current `outp` was computed.

## Operation
- Counter `cnt` is n_columns*data_width bits wide. It increments by 1 every clock and wraps from all-ones to 0.
- Element slicing: v[k] = cnt[k*data_width +: data_width], for k in 0..n_columns-1. All elements are unsigned.
- A (m_rows × n_columns): A[i][j] = v[(i+j) mod n_columns].
- B (n_columns × n_columns): B[k][j] = v[(k+j) mod n_columns].
- C[i][j] = Σ_k A[i][k]*B[k][j], for k = 0..n_columns-1.
  - Each product is 2*data_width bits.
  - The accumulator is EW bits, which is sufficient to hold the maximum sum, so there is no overflow or truncation.
- Packing: C[i][j] occupies outp[(i*n_columns+j)*EW +: EW]. Element 0 is at the LSBs.
- The C computation is purely combinational from `cnt`. Only `cnt`, `outp` and `outp_inps` are registered.

## Timing
- On every rising edge, all three registers update from the pre-edge value of `cnt`:
  - `outp` <= C(cnt)
  - `outp_inps` <= cnt
  - `cnt` <= cnt+1
- `outp` and `outp_inps` are therefore always mutually consistent.
- Latency from `cnt` to outputs is 1 cycle.
- Reset (`rst_n` low): `cnt`, `outp` and `outp_inps` clear to 0 immediately, regardless of `clk`.
- First edge after reset release: `outp_inps` = 0, `outp` = 0, `cnt` = 1.
- Reset asserted mid-sequence: the clear happens immediately, and the sequence restarts from 0 on release.
- Wrap: after `outp_inps` = 2^(n_columns*data_width)-1, the next `outp_inps` is 0 and the next `outp` is 0.
- There is no handshake and there are no stall inputs; the outputs are valid every cycle after reset.

## Structure
- The shared package holds:
  - function `ew(data_width, n_columns)` returning 2*data_width + clog2(n_columns);
  - index helper `circ(i, j, n)` returning (i+j) mod n.
- One sub-module, `matrix_dot_row`: combinational dot product of two n_columns-element vectors, producing an EW-bit result.
  - The top level instantiates it m_rows*n_columns times in a generate loop.

## Test plan
All values below use the default parameters.
- Reset: hold `rst_n` low for 2 cycles, then release.
  - During reset, `outp` = 0 and `outp_inps` = 0.
  - At the first edge after release, `outp_inps` = 0 and `outp` = 0.
- Counter step: `outp_inps` = 1 (v = 1,0,0).
  - C = identity.
  - `outp` = 0x010000000100000001.
- Scaling: `outp_inps` = 2.
  - C = 4·I.
  - `outp` = 0x040000000400000004.
- Mixed: `outp_inps` = 9 (v = 1,1,0).
  - Diagonal elements are 2, off-diagonal elements are 1.
  - `outp` = 0x020101010201010102.
- Maximum and wrap: `outp_inps` = 511 (v = 7,7,7).
  - Every element = 147, so `outp` = 0x939393939393939393.
  - Next cycle: `outp_inps` = 0 and `outp` = 0.
- Asynchronous reset mid-run: assert `rst_n` between clock edges while `outp_inps` = 37.
  - Outputs go to 0 at once.
  - After release, the sequence restarts at 0, 1, 2 and matches a reference model for every value.
